mcse_sha_arbiter: RTL

Shares the single SHA-256 core in the minimum-security module between `NUM_REQ` requesters, such as lifecycle authentication, PUF-signature hashing and host/GPIO hashing. Arbitration is round-robin with grant lock for the whole of a multi-block message. The block sequences `sha_init`/`sha_next` and returns each digest to its owner. It sits between the MCSE control unit's requesters and the `sha_*` port group of the minimum-security module.

---
 rtl/mcse_sha_arb_pkg.sv | 14 +
 rtl/mcse_rr_picker.sv | 28 ++
 rtl/mcse_sha_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mcse_sha_arb_pkg.sv
// Shared types and widths for the MCSE SHA-256 core arbiter.
package mcse_sha_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } sha_arb_state_t;

  localparam int SHA_BLOCK_W  = 512;
  localparam int SHA_DIGEST_W = 256;

endpackage

// File: rtl/mcse_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module mcse_rr_picker #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt
);

  logic [PTR_W:0] pos;
  logic           found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, ptr} + (PTR_W+1)'(k);
      if (pos >= (PTR_W+1)'(NUM_REQ)) pos = pos - (PTR_W+1)'(NUM_REQ);
      if (!found && req[pos[PTR_W-1:0]]) begin
        gnt[pos[PTR_W-1:0]] = 1'b1;
        found               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mcse_sha_arbiter.sv
// Round-robin arbiter sharing one SHA-256 core, grant locked for a whole message.
// Optional core watchdog: define MCSE_SHA_ARB_TIMEOUT_EN.
//   state | meaning
//   IDLE  | no owner; pick next requester round-robin
//   ISSUE | owner held; wait for core ready + block, pulse init/next
//   BUSY  | core hashing; wait for ready && digest_valid
//   DONE  | digest returned, grant released; one dead cycle before IDLE
module mcse_sha_arbiter
  import mcse_sha_arb_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*SHA_BLOCK_W-1:0] req_block,
  input  logic [NUM_REQ-1:0]             req_last,
  input  logic [NUM_REQ-1:0]             req_sel,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             req_ack,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [SHA_DIGEST_W-1:0]        rsp_digest,
  output logic [NUM_REQ-1:0]             err,
  output logic                           busy,
  output logic [SHA_BLOCK_W-1:0]         sha_block,
  output logic                           sha_init,
  output logic                           sha_next,
  output logic                           sha_sel,
  input  logic                           sha_ready,
  input  logic                           sha_digest_valid,
  input  logic [SHA_DIGEST_W-1:0]        sha_digest
);

  localparam int IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("mcse_sha_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
  end

  sha_arb_state_t         state_q;
  logic [IW-1:0]          rr_ptr_q;
  logic [IW-1:0]          idx_q;
  logic [IW-1:0]          pick_idx;
  logic [IW-1:0]          next_ptr;
  logic [NUM_REQ-1:0]     pick;
  logic                   first_q;
  logic                   last_q;
  logic                   done_ok;
  logic [SHA_BLOCK_W-1:0] own_block;

`ifdef MCSE_SHA_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q;
`endif

  mcse_rr_picker #(.NUM_REQ(NUM_REQ), .PTR_W(IW)) u_picker (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (pick)
  );

  always_comb begin
    pick_idx  = '0;
    own_block = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick[k]) pick_idx = IW'(k);
      if (idx_q == IW'(k)) own_block = req_block[k*SHA_BLOCK_W +: SHA_BLOCK_W];
    end
  end

  assign next_ptr = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
  // The start pulse is high exactly during the first BUSY cycle, where the
  // core's ready/digest_valid still reflect the previous block.
  assign done_ok  = !(sha_init || sha_next) && sha_ready && sha_digest_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      idx_q      <= '0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      gnt        <= '0;
      req_ack    <= '0;
      rsp_valid  <= '0;
      rsp_digest <= '0;
      err        <= '0;
      busy       <= 1'b0;
      sha_block  <= '0;
      sha_init   <= 1'b0;
      sha_next   <= 1'b0;
      sha_sel    <= 1'b0;
`ifdef MCSE_SHA_ARB_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      req_ack   <= '0;
      rsp_valid <= '0;
      err       <= '0;
      sha_init  <= 1'b0;
      sha_next  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|req_valid) begin
            gnt     <= pick;
            busy    <= 1'b1;
            idx_q   <= pick_idx;
            sha_sel <= req_sel[pick_idx];
            first_q <= 1'b1;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (sha_ready && req_valid[idx_q]) begin
            sha_block <= own_block;
            sha_init  <= first_q;
            sha_next  <= !first_q;
            req_ack   <= gnt;
            last_q    <= req_last[idx_q];
            first_q   <= 1'b0;
            state_q   <= ST_BUSY;
`ifdef MCSE_SHA_ARB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
          end
        end
        ST_BUSY: begin
          if (done_ok) begin
            if (last_q) begin
              rsp_digest <= sha_digest;
              rsp_valid  <= gnt;
              gnt        <= '0;
              busy       <= 1'b0;
              sha_sel    <= 1'b0;
              rr_ptr_q   <= next_ptr;
              state_q    <= ST_DONE;
            end else begin
              state_q <= ST_ISSUE;
            end
          end
`ifdef MCSE_SHA_ARB_TIMEOUT_EN
          else if (cnt_q == TMO_LAST) begin
            err      <= gnt;
            gnt      <= '0;
            busy     <= 1'b0;
            sha_sel  <= 1'b0;
            rr_ptr_q <= next_ptr;
            state_q  <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
